// File: rtl/mio_kbd_decoder_if.sv
`default_nettype none
// ============================================================================
// mio_kbd_decoder_if : PS/2 byte-pop and MIO keyboard-port signal bundle
// Rev 1.0
// ============================================================================
interface mio_kbd_decoder_if;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_rdn;
  logic       io_rdn;
  logic [7:0] key_data;
  logic       ready;
  logic       overflow;

  modport master (
    output ps2_data, ps2_ready, io_rdn,
    input  ps2_rdn, key_data, ready, overflow
  );

  modport slave (
    input  ps2_data, ps2_ready, io_rdn,
    output ps2_rdn, key_data, ready, overflow
  );
endinterface
`default_nettype wire

// File: rtl/mio_kbd_decoder.sv
`default_nettype none
// ============================================================================
// mio_kbd_decoder : PS/2 set-2 scan codes to ASCII, buffered for the MIO bus
// Rev 1.0
// ============================================================================
module mio_kbd_decoder #(
  parameter int DEPTH_LOG2 = 3
) (
  input  wire logic        clk,
  input  wire logic        clrn,
  mio_kbd_decoder_if.slave bus
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  typedef enum logic {
    PH_FETCH  = 1'b0,
    PH_DECODE = 1'b1
  } phase_t;

  typedef enum logic [1:0] {
    PX_BASE = 2'd0,
    PX_E0   = 2'd1,
    PX_F0   = 2'd2,
    PX_E0F0 = 2'd3
  } prefix_t;

  phase_t                phase_q, phase_d;
  prefix_t               prefix_q, prefix_d;
  logic [7:0]            byte_q, byte_d;
  logic                  shift_l_q, shift_l_d;
  logic                  shift_r_q, shift_r_d;
  logic                  caps_q, caps_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            mem_q [DEPTH];

  logic       w_fetch;
  logic       w_push;
  logic [7:0] w_push_char;
  logic [8:0] w_xlate;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_wr;

  // Returns {mapped, ascii}; letters are shifted to uppercase when upper=1.
  function automatic logic [8:0] f_xlate(input logic [7:0] code, input logic upper);
    logic [7:0] c;
    logic       letter;
    c = 8'h00;
    case (code)
      8'h1C: c = 8'h61;  8'h32: c = 8'h62;  8'h21: c = 8'h63;  8'h23: c = 8'h64;
      8'h24: c = 8'h65;  8'h2B: c = 8'h66;  8'h34: c = 8'h67;  8'h33: c = 8'h68;
      8'h43: c = 8'h69;  8'h3B: c = 8'h6A;  8'h42: c = 8'h6B;  8'h4B: c = 8'h6C;
      8'h3A: c = 8'h6D;  8'h31: c = 8'h6E;  8'h44: c = 8'h6F;  8'h4D: c = 8'h70;
      8'h15: c = 8'h71;  8'h2D: c = 8'h72;  8'h1B: c = 8'h73;  8'h2C: c = 8'h74;
      8'h3C: c = 8'h75;  8'h2A: c = 8'h76;  8'h1D: c = 8'h77;  8'h22: c = 8'h78;
      8'h35: c = 8'h79;  8'h1A: c = 8'h7A;
      8'h45: c = 8'h30;  8'h16: c = 8'h31;  8'h1E: c = 8'h32;  8'h26: c = 8'h33;
      8'h25: c = 8'h34;  8'h2E: c = 8'h35;  8'h36: c = 8'h36;  8'h3D: c = 8'h37;
      8'h3E: c = 8'h38;  8'h46: c = 8'h39;
      8'h29: c = 8'h20;  8'h5A: c = 8'h0D;  8'h66: c = 8'h08;
      default: c = 8'h00;
    endcase
    letter = (c >= 8'h61) && (c <= 8'h7A);
    return {(c != 8'h00), (letter && upper) ? (c - 8'h20) : c};
  endfunction

  always_ff @(posedge clk) begin
    if (!clrn) begin
      phase_q    <= PH_FETCH;
      prefix_q   <= PX_BASE;
      byte_q     <= 8'h00;
      shift_l_q  <= 1'b0;
      shift_r_q  <= 1'b0;
      caps_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      prefix_q   <= prefix_d;
      byte_q     <= byte_d;
      shift_l_q  <= shift_l_d;
      shift_r_q  <= shift_r_d;
      caps_q     <= caps_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= w_push_char;
    end
  end

  always_comb begin
    phase_d     = phase_q;
    prefix_d    = prefix_q;
    byte_d      = byte_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    caps_d      = caps_q;
    w_fetch     = 1'b0;
    w_push      = 1'b0;
    w_push_char = 8'h00;
    w_xlate     = f_xlate(byte_q, (shift_l_q | shift_r_q) ^ caps_q);
    case (phase_q)
      PH_FETCH: begin
        // No pop during reset so the receiver never loses a byte.
        if (bus.ps2_ready && clrn) begin
          w_fetch = 1'b1;
          byte_d  = bus.ps2_data;
          phase_d = PH_DECODE;
        end
      end
      PH_DECODE: begin
        phase_d = PH_FETCH;
        if (byte_q == 8'hE0) begin
          prefix_d = PX_E0;
        end else if (byte_q == 8'hF0) begin
          prefix_d = (prefix_q == PX_E0) ? PX_E0F0 : PX_F0;
        end else begin
          prefix_d = PX_BASE;
          case (prefix_q)
            PX_BASE: begin
              if (byte_q == 8'h12) begin
                shift_l_d = 1'b1;
              end else if (byte_q == 8'h59) begin
                shift_r_d = 1'b1;
              end else if (byte_q == 8'h58) begin
                caps_d = ~caps_q;
              end else begin
                w_push      = w_xlate[8];
                w_push_char = w_xlate[7:0];
              end
            end
            PX_F0: begin
              if (byte_q == 8'h12) shift_l_d = 1'b0;
              if (byte_q == 8'h59) shift_r_d = 1'b0;
            end
            PX_E0: begin
              w_push = 1'b1;
              case (byte_q)
                8'h75:   w_push_char = 8'h11;
                8'h72:   w_push_char = 8'h12;
                8'h6B:   w_push_char = 8'h13;
                8'h74:   w_push_char = 8'h14;
                default: w_push      = 1'b0;
              endcase
            end
            default: ;
          endcase
        end
      end
      default: phase_d = PH_FETCH;
    endcase
  end

  always_comb begin
    w_empty    = (count_q == '0);
    w_full     = (count_q == FULL_COUNT);
    w_pop      = clrn && !bus.io_rdn && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    w_wr       = clrn && w_push && (!w_full || w_pop);
    overflow_d = overflow_q | (w_push && w_full && !w_pop);
    wr_ptr_d   = w_wr  ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = w_pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({w_wr, w_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  assign bus.ps2_rdn  = ~w_fetch;
  assign bus.ready    = clrn && !w_empty;
  assign bus.key_data = bus.ready ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_mio_kbd_decoder.sv
`default_nettype none
// ============================================================================
// tb_mio_kbd_decoder : directed plus randomized bench with a behavioural model
// Rev 1.0
// ============================================================================
module tb_mio_kbd_decoder;

  localparam int DEPTH = 8;

  logic clk;
  logic clrn;
  int   errors = 0;
  int   checks = 0;
  int   rdn_cnt = 0;

  mio_kbd_decoder_if bus ();

  mio_kbd_decoder #(.DEPTH_LOG2(3)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.ps2_rdn === 1'b0) rdn_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model state
  logic [7:0] m_q [$];
  bit m_e0, m_f0, m_shl, m_shr, m_caps, m_ovf;

  logic [7:0] lt [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                          8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                          8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                          8'h35, 8'h1A};
  logic [7:0] dg [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                          8'h3E, 8'h46};
  logic [7:0] pool [24] = '{8'h1C, 8'h32, 8'h1A, 8'h4D, 8'h2C, 8'h45, 8'h16, 8'h46,
                            8'h12, 8'h59, 8'h58, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h72,
                            8'h6B, 8'h74, 8'h29, 8'h5A, 8'h66, 8'h0E, 8'h76, 8'h3A};

  function automatic void model_reset();
    m_q.delete();
    m_e0 = 0; m_f0 = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_ovf = 0;
  endfunction

  function automatic void model_push(input logic [7:0] c);
    if (m_q.size() < DEPTH) m_q.push_back(c);
    else m_ovf = 1;
  endfunction

  function automatic logic [8:0] model_xlate(input logic [7:0] code);
    bit upper;
    upper = (m_shl || m_shr) != m_caps;
    for (int i = 0; i < 26; i++)
      if (code == lt[i]) return {1'b1, 8'(int'(upper ? 8'h41 : 8'h61) + i)};
    for (int i = 0; i < 10; i++)
      if (code == dg[i]) return {1'b1, 8'(8'h30 + i)};
    if (code == 8'h29) return {1'b1, 8'h20};
    if (code == 8'h5A) return {1'b1, 8'h0D};
    if (code == 8'h66) return {1'b1, 8'h08};
    return 9'h000;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [8:0] x;
    if (b == 8'hE0) begin m_e0 = 1; m_f0 = 0; return; end
    if (b == 8'hF0) begin m_e0 = m_e0 && !m_f0; m_f0 = 1; return; end
    if (!m_e0 && !m_f0) begin
      if (b == 8'h12) m_shl = 1;
      else if (b == 8'h59) m_shr = 1;
      else if (b == 8'h58) m_caps = !m_caps;
      else begin
        x = model_xlate(b);
        if (x[8]) model_push(x[7:0]);
      end
    end else if (m_f0 && !m_e0) begin
      if (b == 8'h12) m_shl = 0;
      if (b == 8'h59) m_shr = 0;
    end else if (m_e0 && !m_f0) begin
      if (b == 8'h75) model_push(8'h11);
      if (b == 8'h72) model_push(8'h12);
      if (b == 8'h6B) model_push(8'h13);
      if (b == 8'h74) model_push(8'h14);
    end
    m_e0 = 0; m_f0 = 0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pop_dec = 1'b0);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.ps2_data = b; bus.ps2_ready = 1'b1;
    @(negedge clk);
    while (bus.ps2_rdn !== 1'b0 && n < 8) begin @(negedge clk); n++; end
    if (n >= 8) chk("fetch_timeout", {7'b0, bus.ps2_rdn}, 8'h00);
    @(posedge clk); #1;
    bus.ps2_ready = 1'b0; bus.ps2_data = 8'h00;
    if (pop_dec) bus.io_rdn = 1'b0;
    @(posedge clk); #1;
    bus.io_rdn = 1'b1;
    if (pop_dec && m_q.size() > 0) void'(m_q.pop_front());
    model_byte(b);
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, {7'b0, bus.ready}, {7'b0, m_q.size() != 0});
    chk({tag, "_key"}, bus.key_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
    chk({tag, "_ovf"}, {7'b0, bus.overflow}, {7'b0, m_ovf});
  endtask

  task automatic read_char(input string tag, input int lit = -1);
    @(negedge clk);
    chk({tag, "_ready"}, {7'b0, bus.ready}, {7'b0, m_q.size() != 0});
    chk(tag, bus.key_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
    if (lit >= 0) chk({tag, "_lit"}, bus.key_data, 8'(lit));
    @(posedge clk); #1 bus.io_rdn = 1'b0;
    @(posedge clk); #1 bus.io_rdn = 1'b1;
    if (m_q.size() != 0) void'(m_q.pop_front());
  endtask

  task automatic do_reset(input bit hold_ready);
    @(posedge clk); #1;
    clrn = 1'b0;
    if (hold_ready) begin bus.ps2_ready = 1'b1; bus.ps2_data = 8'h1C; end
    @(negedge clk);
    chk("rst_ready", {7'b0, bus.ready}, 8'h00);
    chk("rst_key", bus.key_data, 8'h00);
    chk("rst_rdn", {7'b0, bus.ps2_rdn}, 8'h01);
    @(posedge clk); #1;
    clrn = 1'b1; bus.ps2_ready = 1'b0; bus.ps2_data = 8'h00;
    model_reset();
  endtask

  initial begin
    int c0, lows, adj;
    logic prev;
    clrn = 1'b0;
    bus.ps2_data = 8'h00; bus.ps2_ready = 1'b0; bus.io_rdn = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset(1'b1);
    check_state("reset");

    // Make/break of 'a'
    c0 = rdn_cnt;
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    read_char("t1_a", 8'h61);
    check_state("t1_empty");
    chk("t1_rdn_pulses", 8'(rdn_cnt - c0), 8'd3);

    // Shift, caps and digits
    send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12); send_byte(8'h1C);
    read_char("t2_A", 8'h41);
    read_char("t2_a", 8'h61);
    send_byte(8'h58); send_byte(8'h1C);
    read_char("t2_capsA", 8'h41);
    send_byte(8'h12); send_byte(8'h1C);
    read_char("t2_capsshift_a", 8'h61);
    send_byte(8'h16);
    read_char("t2_digit1", 8'h31);
    send_byte(8'hF0); send_byte(8'h12); send_byte(8'h58);
    check_state("t2_end");

    // Extended codes
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'hF0);
    send_byte(8'h75); send_byte(8'h0E);
    read_char("t3_up", 8'h11);
    check_state("t3_empty");

    // Overflow, then full FIFO with simultaneous pop
    for (int i = 0; i < 9; i++) send_byte(lt[i]);
    check_state("t4_full");
    for (int i = 0; i < 8; i++) read_char("t4_rd", 8'h61 + i);
    check_state("t4_drained");
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) send_byte(lt[i], i == 8);
    check_state("t4b_full");
    for (int i = 0; i < 8; i++) read_char("t4b_rd", 8'h62 + i);
    check_state("t4b_drained");

    // Reset discards F0 prefix
    send_byte(8'h1C);
    send_byte(8'hF0);
    do_reset(1'b1);
    send_byte(8'h1C);
    read_char("t5_a", 8'h61);
    check_state("t5_empty");

    // Continuous ps2_ready: one pop every other cycle
    @(posedge clk); #1;
    bus.ps2_data = 8'h0E; bus.ps2_ready = 1'b1;
    lows = 0; adj = 0; prev = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ps2_rdn === 1'b0) begin lows++; if (prev === 1'b0) adj++; end
      prev = bus.ps2_rdn;
    end
    @(posedge clk); #1;
    bus.ps2_ready = 1'b0; bus.ps2_data = 8'h00;
    for (int i = 0; i < 5; i++) model_byte(8'h0E);
    chk("t6_lows", 8'(lows), 8'd5);
    chk("t6_adjacent", 8'(adj), 8'd0);
    for (int i = 0; i < 3; i++) read_char("t6_empty_pop");
    send_byte(8'h32);
    read_char("t6_b", 8'h62);
    check_state("t6_end");

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        send_byte(pool[$urandom_range(0, 23)]);
        check_state("rnd_step");
      end else begin
        read_char("rnd_read");
      end
    end
    while (m_q.size() != 0) read_char("rnd_drain");
    check_state("rnd_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mio_kbd_decoder.md
Name: mio_kbd_decoder

Overview:
Sits between the PS/2 receiver (mio_ps2) and the MIO bus keyboard port. It pops raw set-2 scan-code bytes from the receiver and tracks prefixes (E0, F0) and the Shift and CapsLock state. It translates make codes to ASCII and buffers the characters in a small FIFO. The CPU reads one character per read strobe through the same io_rdn/key_data/ready/overflow contract the bus already uses.

Parameters:
DEPTH_LOG2, 3, FIFO depth = 2^DEPTH_LOG2 entries of 8 bits.

Ports:
clk  input  1  system clock (sys_clk domain)
clrn  input  1  synchronous active-low reset
ps2_data  input  8  head byte of mio_ps2 FIFO, valid while ps2_ready=1
ps2_ready  input  1  mio_ps2 has at least one byte
ps2_rdn  output  1  active-low pop strobe to mio_ps2, one cycle per byte
io_rdn  input  1  active-low read strobe from mio_bus
key_data  output  8  ASCII character at FIFO head; 8'h00 when empty
ready  output  1  FIFO non-empty
overflow  output  1  sticky: a character was dropped because the FIFO was full

Behaviour:
- Reset: clrn is sampled on the rising clk edge; when low, all state clears on that edge.
  - Cleared state: FIFO pointers and count, byte register, phase=FETCH, prefix=BASE, shift_l=0, shift_r=0, caps=0, overflow=0.
  - Outputs during reset: ps2_rdn=1, ready=0, key_data=8'h00.
  - A reset in the middle of a sequence (for example after F0) discards the prefix; the next byte is treated fresh.
- Phase FSM (two states), so at most one raw byte is accepted every 2 cycles:
  - FETCH: if ps2_ready=1, drive ps2_rdn=0 combinationally for this cycle, latch ps2_data into byte_r, go to DECODE. Otherwise stay, with ps2_rdn=1.
  - DECODE: apply the prefix rules below to byte_r, optionally push one character, return to FETCH. ps2_rdn=1.
- Prefix FSM, updated only in DECODE:
  - byte E0 (any prefix): go to E0.
  - byte F0: BASE goes to F0; E0 goes to E0F0; F0 or E0F0 goes to F0.
  - Other bytes with prefix BASE (make code):
    - 12 sets shift_l; 59 sets shift_r.
    - 58 toggles caps.
    - Otherwise translate; push if mapped. Next prefix BASE.
  - Other bytes with prefix F0 (break code): 12 clears shift_l; 59 clears shift_r; nothing is pushed. Next prefix BASE.
  - Other bytes with prefix E0: push 75 as 8'h11, 72 as 8'h12, 6B as 8'h13, 74 as 8'h14; drop all others. Next prefix BASE.
  - Other bytes with prefix E0F0: drop. Next prefix BASE.
- Translation (scan-code set 2):
  - Letters a–z map to lowercase ASCII. They map to uppercase when (shift_l|shift_r) XOR caps.
  - Digits 0–9 (45,16,1E,26,25,2E,36,3D,3E,46) map to '0'–'9' and ignore Shift.
  - 29 maps to 8'h20, 5A to 8'h0D, 66 to 8'h08.
  - All other codes are unmapped and are dropped without side effects.
- Latency: a character is visible on ready/key_data in the second cycle after the cycle in which ps2_rdn was low.
- FIFO:
  - Push happens at the end of the DECODE cycle.
  - Pop happens on any clock edge where io_rdn=0 and ready=1; one entry per cycle while io_rdn stays low.
  - Pop while empty is ignored.
  - Push while full (and no pop in the same cycle) drops the character and sets overflow; overflow stays set until reset.
  - Simultaneous push and pop is always legal, including when full: count is unchanged and no drop occurs.
  - Pointers wrap modulo 2^DEPTH_LOG2.
  - key_data and ready are combinational from FIFO state; there is no read latency.

Test Plan:
- Byte stream 1C, F0, 1C, then one io_rdn pulse -> a single character 8'h61 ('a'); ready falls to 0 after the pop; ps2_rdn pulsed exactly 3 times.
- Stream 12, 1C, F0, 12, 1C -> FIFO holds 8'h41, 8'h61. Then 58, 1C -> 8'h41; then 12, 1C -> 8'h61; then 16 -> 8'h31.
- Stream E0, 75, E0, F0, 75, 0E (unmapped) -> exactly one character, 8'h11; no stray pushes.
- DEPTH_LOG2=3: push 9 letters with no reads -> ready=1, overflow=1, first 8 characters read back in order, 9th absent. Repeat with io_rdn held low during the 9th push -> overflow stays 0.
- Send F0, assert clrn=0 for one cycle, then send 1C -> 8'h61 is pushed; ready=0 and key_data=8'h00 during reset.
- Hold ps2_ready=1 continuously -> ps2_rdn is low on alternate cycles only; io_rdn pulses with the FIFO empty leave pointers unchanged.
